// File: rtl/mult_accum_pkg.sv
// Shared constants and FSM encoding for the multiply-accumulate reduction block.
package mult_pkg;

  localparam int SIZE_DEF  = 8;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;

  // 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_accum_if.sv
// Product-in / result-out bus of mult_accum; master drives requests, slave is the accumulator.
interface mult_accum_if
  import mult_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) ();

  logic               start;
  logic [LEN_W-1:0]   len;
  logic               prod_valid;
  logic [2*SIZE-1:0]  prod;
  logic               prod_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               acc_valid;
  logic               acc_ready;
  logic               ovf;
  logic               busy;

  modport master (
    output start, len, prod_valid, prod, acc_ready,
    input  prod_ready, acc_out, acc_valid, ovf, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, acc_ready,
    output prod_ready, acc_out, acc_valid, ovf, busy
  );

endinterface

// File: rtl/mult_accum_sat_add.sv
// Combinational ACC_W-bit unsigned adder that clamps to all-ones on carry-out.
module sat_add #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  function automatic logic [ACC_W:0] sat(input logic [ACC_W:0] full);
    if (full[ACC_W])
      return {1'b1, {ACC_W{1'b1}}};
    return full;
  endfunction

  logic [ACC_W:0] full;

  assign full       = {1'b0, a} + {1'b0, b};
  assign {ovf, sum} = sat(full);

endmodule

// File: rtl/mult_accum.sv
// Accumulates a programmed count of multiplier products into a saturating sum and
// hands the result out over a valid/ready handshake.
module mult_accum
  import mult_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic         clk,
  input logic         rst,
  mult_accum_if.slave bus
);

  localparam int PROD_W = 2 * SIZE;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             ovf, ovf_nxt;

  logic [PROD_W-1:0] prod_w;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;

  assign prod_w = bus.prod;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (ACC_W'(prod_w)),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // State register; rst is active-low and discards any partial sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = bus.len;
          state_nxt     = (bus.len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_nxt       = sum;
          ovf_nxt       = ovf | sum_ovf;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.acc_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come straight from registers, so no input reaches an output combinationally.
  assign bus.prod_ready = (state == ACCUM);
  assign bus.acc_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.acc_out    = acc;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_mult_accum.sv
// Self-checking bench: a 24-bit and a 17-bit accumulator share one stimulus stream.
module tb_mult_accum;

  localparam int SIZE = 8;
  localparam int LEN_W = 8;
  localparam int AW_A = 24;
  localparam int AW_B = 17;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [LEN_W-1:0] len;
  logic pv;
  logic [2*SIZE-1:0] prod;
  logic acc_ready;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_accum_if #(.SIZE(SIZE), .ACC_W(AW_A), .LEN_W(LEN_W)) bus_a ();
  mult_accum_if #(.SIZE(SIZE), .ACC_W(AW_B), .LEN_W(LEN_W)) bus_b ();

  assign bus_a.start = start;      assign bus_b.start = start;
  assign bus_a.len = len;          assign bus_b.len = len;
  assign bus_a.prod_valid = pv;    assign bus_b.prod_valid = pv;
  assign bus_a.prod = prod;        assign bus_b.prod = prod;
  assign bus_a.acc_ready = acc_ready;
  assign bus_b.acc_ready = acc_ready;

  mult_accum #(.SIZE(SIZE), .ACC_W(AW_A), .LEN_W(LEN_W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mult_accum #(.SIZE(SIZE), .ACC_W(AW_B), .LEN_W(LEN_W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Presents one product and holds it until accepted (bounded).
  task automatic send(input logic [2*SIZE-1:0] p);
    int guard;
    guard = 0;
    pv = 1'b1;
    prod = p;
    while (!bus_a.prod_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: prod_ready never rose, want 1");
    end
    tick();
    pv = 1'b0;
  endtask

  task automatic drain();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_checks++;
    if (bus_a.acc_valid !== 1'b0 || bus_b.acc_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_acc_valid: got %b/%b want 0/0", bus_a.acc_valid, bus_b.acc_valid);
    end
    n_checks++;
    if (bus_a.prod_ready !== 1'b0) begin n_fail++; $display("FAIL reset_prod_ready: got %b want 0", bus_a.prod_ready); end
    n_checks++;
    if (bus_a.acc_out !== 24'h0 || bus_a.ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_acc_out: got %h ovf %b want 0 ovf 0", bus_a.acc_out, bus_a.ovf);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_job(3);
    pv = 1'b1;
    prod = 16'hFE01;
    tick();
    tick();
    n_checks++;
    if (bus_a.acc_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus_a.acc_valid); end
    tick();
    pv = 1'b0;
    n_checks++;
    if (bus_a.acc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1", bus_a.acc_valid); end
    n_checks++;
    if (bus_a.acc_out !== 24'h02FA03 || bus_a.ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: got %h ovf %b want 02fa03 ovf 0", bus_a.acc_out, bus_a.ovf);
    end
    drain();
    n_checks++;
    if (bus_a.acc_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: got valid %b busy %b want 0 0", bus_a.acc_valid, bus_a.busy);
    end
  endtask

  task automatic test_bubbles();
    start_job(2);
    send(16'h0006);
    tick();
    tick();
    send(16'h0014);
    // Garbage offered while in DONE must never be taken.
    pv = 1'b1;
    prod = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 24'h00001A || bus_a.prod_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bubbles_hold[%0d]: got valid %b out %h ready %b want 1 00001a 0",
                 i, bus_a.acc_valid, bus_a.acc_out, bus_a.prod_ready);
      end
      tick();
    end
    pv = 1'b0;
    drain();
  endtask

  task automatic test_zero_len();
    pv = 1'b1;
    prod = 16'h0055;
    start_job(0);
    n_checks++;
    if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 24'h0 || bus_a.ovf !== 1'b0 || bus_a.prod_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got valid %b out %h ovf %b ready %b want 1 0 0 0",
               bus_a.acc_valid, bus_a.acc_out, bus_a.ovf, bus_a.prod_ready);
    end
    drain();
    pv = 1'b0;
    n_checks++;
    if (bus_a.acc_out !== 24'h0) begin n_fail++; $display("FAIL zero_len_no_accept: got %h want 0", bus_a.acc_out); end
  endtask

  task automatic test_saturation();
    start_job(3);
    for (int i = 0; i < 3; i++) send(16'hFE01);
    n_checks++;
    if (bus_b.acc_out !== 17'h1FFFF || bus_b.ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat_17: got %h ovf %b want 1ffff ovf 1", bus_b.acc_out, bus_b.ovf);
    end
    n_checks++;
    if (bus_a.acc_out !== 24'h02FA03 || bus_a.ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_24_nosat: got %h ovf %b want 02fa03 ovf 0", bus_a.acc_out, bus_a.ovf);
    end
    drain();
    start_job(1);
    send(16'h0001);
    n_checks++;
    if (bus_b.acc_out !== 17'h00001 || bus_b.ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got %h ovf %b want 00001 ovf 0", bus_b.acc_out, bus_b.ovf);
    end
    drain();
  endtask

  task automatic test_start_ignored();
    start_job(2);
    send(16'h0003);
    start = 1'b1;
    len = 8'd5;
    tick();
    start = 1'b0;
    send(16'h0004);
    n_checks++;
    if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 24'h000007) begin
      n_fail++; $display("FAIL ignore_accum: got valid %b out %h want 1 000007", bus_a.acc_valid, bus_a.acc_out);
    end
    start = 1'b1;
    acc_ready = 1'b1;
    tick();
    start = 1'b0;
    acc_ready = 1'b0;
    n_checks++;
    if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_done: got busy %b want 0", bus_a.busy); end
    tick();
    n_checks++;
    if (bus_a.busy !== 1'b0 || bus_a.prod_ready !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_job: got busy %b ready %b want 0 0", bus_a.busy, bus_a.prod_ready);
    end
  endtask

  task automatic test_midjob_reset();
    start_job(4);
    send(16'h0100);
    send(16'h0200);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (bus_a.busy !== 1'b0 || bus_a.acc_valid !== 1'b0 || bus_a.prod_ready !== 1'b0 || bus_a.acc_out !== 24'h0) begin
      n_fail++;
      $display("FAIL midjob_reset: got busy %b valid %b ready %b out %h want 0 0 0 0",
               bus_a.busy, bus_a.acc_valid, bus_a.prod_ready, bus_a.acc_out);
    end
    start_job(1);
    send(16'h0007);
    n_checks++;
    if (bus_a.acc_valid !== 1'b1 || bus_a.acc_out !== 24'h000007 || bus_b.acc_out !== 17'h00007) begin
      n_fail++; $display("FAIL midjob_rerun: got %h/%h want 000007/00007", bus_a.acc_out, bus_b.acc_out);
    end
    drain();
  endtask

  // Reference: the result is the plain sum of the job's products, clamped to the
  // accumulator's maximum, with ovf set whenever the true sum exceeded that maximum.
  task automatic test_random();
    longint sum, max_a, max_b, exp_a, exp_b;
    int n, guard;
    logic [2*SIZE-1:0] p;
    max_a = (longint'(1) << AW_A) - 1;
    max_b = (longint'(1) << AW_B) - 1;
    for (int job = 0; job < 12; job++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      sum = 0;
      start_job(n);
      for (int k = 0; k < n; k++) begin
        p = ($urandom_range(0, 2) == 0) ? 16'hFE01 : 16'($urandom);
        sum += longint'(p);
        for (int b = 0; b < int'($urandom_range(0, 2)); b++) tick();
        send(p);
      end
      guard = 0;
      while (!bus_a.acc_valid && guard < 20) begin tick(); guard++; end
      exp_a = (sum > max_a) ? max_a : sum;
      exp_b = (sum > max_b) ? max_b : sum;
      n_checks++;
      if (bus_a.acc_valid !== 1'b1 || longint'(bus_a.acc_out) != exp_a || bus_a.ovf !== (sum > max_a)) begin
        n_fail++;
        $display("FAIL rand_a[%0d]: got valid %b out %h ovf %b want 1 %h %b",
                 job, bus_a.acc_valid, bus_a.acc_out, bus_a.ovf, exp_a, sum > max_a);
      end
      n_checks++;
      if (bus_b.acc_valid !== 1'b1 || longint'(bus_b.acc_out) != exp_b || bus_b.ovf !== (sum > max_b)) begin
        n_fail++;
        $display("FAIL rand_b[%0d]: got valid %b out %h ovf %b want 1 %h %b",
                 job, bus_b.acc_valid, bus_b.acc_out, bus_b.ovf, exp_b, sum > max_b);
      end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
      drain();
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    pv = 1'b0;
    prod = '0;
    acc_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_saturation();
    test_start_ignored();
    test_midjob_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
